// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson run controller: FSM states, direction/mode
// constants and the legal-code check used for illegal-ring detection.
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  localparam int MAX_WIDTH = 32;

  // A Johnson code has at most one boundary between adjacent differing bits
  // within the low 'width' bits; anything with more is off the ring.
  function automatic logic isLegalCode(input logic [MAX_WIDTH-1:0] code,
                                       input int width);
    int edgesSeen;
    edgesSeen = 0;
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if ((i < width - 1) && (code[i] != code[i+1])) begin
        edgesSeen++;
      end
    end
    return (edgesSeen <= 1);
  endfunction

endpackage

// File: rtl/johnson_core.sv
// WIDTH-stage Johnson shift register with step enable, direction select and
// synchronous clear.
module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Up feeds ~msb into bit 0; down feeds ~lsb into the msb.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (dir_i == DIR_DOWN) begin
        count_d = {~count_q[0], count_q[WIDTH-1:1]};
      end else begin
        count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run controller for a Johnson counter: start/pause/stop sequencing, one-shot
// cycle counting, wrap/done/illegal-state reporting and phase decode.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  localparam int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic               dir_i,
  input  logic [CNT_W-1:0]   numCycles_i,
  input  logic               pause_i,
  input  logic               stop_i,
  output logic [WIDTH-1:0]   count_o,
  output logic [WIDTH-1:0]   countBar_o,
  output logic [PHASE_W-1:0] phaseIdx_o,
  output logic               busy_o,
  output logic               wrap_o,
  output logic               done_o,
  output logic               errIllegal_o,
  output logic [CNT_W-1:0]   cyclesLeft_o
);

  localparam logic [WIDTH-1:0] UP_LAST   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] DOWN_LAST = WIDTH'(1);

  state_e           state_q, state_d;
  logic             modeLatched_q, modeLatched_d;
  logic             dirLatched_q, dirLatched_d;
  logic [CNT_W-1:0] cyclesLeft_q, cyclesLeft_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             errIllegal_q, errIllegal_d;

  logic [WIDTH-1:0] count;
  logic             coreEn;
  logic             coreClr;
  logic             advance;
  logic             finishOnZero;
  logic             legal;
  logic             stepToZero;
  int               onesCount;

  johnson_core #(.WIDTH(WIDTH)) uCore (
    .clk     (clk),
    .rst     (rst),
    .en_i    (coreEn),
    .dir_i   (dirLatched_q),
    .clr_i   (coreClr),
    .count_o (count)
  );

  assign legal      = isLegalCode(MAX_WIDTH'(count), WIDTH);
  assign stepToZero = (dirLatched_q == DIR_DOWN) ? (count == DOWN_LAST) : (count == UP_LAST);

  // Illegal-ring recovery overrides every state; otherwise the state decides
  // whether this edge advances, and a step into 0 is handled in one place.
  always_comb begin
    state_d       = state_q;
    modeLatched_d = modeLatched_q;
    dirLatched_d  = dirLatched_q;
    cyclesLeft_d  = cyclesLeft_q;
    wrap_d        = 1'b0;
    done_d        = 1'b0;
    errIllegal_d  = 1'b0;
    coreClr       = 1'b0;
    advance       = 1'b0;
    finishOnZero  = 1'b0;

    if (!legal) begin
      coreClr      = 1'b1;
      state_d      = ST_IDLE;
      cyclesLeft_d = '0;
      errIllegal_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          coreClr = 1'b1;
          if (start_i && ((mode_i == MODE_CONT) || (numCycles_i != '0))) begin
            state_d       = ST_RUN;
            modeLatched_d = mode_i;
            dirLatched_d  = dir_i;
            cyclesLeft_d  = (mode_i == MODE_CONT) ? '0 : numCycles_i;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            if (count == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d      = ST_DRAIN;
              advance      = 1'b1;
              finishOnZero = 1'b1;
            end
          end else if (pause_i) begin
            state_d = ST_HOLD;
          end else begin
            advance = 1'b1;
          end
        end
        ST_HOLD: begin
          if (stop_i) begin
            if (count == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end else if (!pause_i) begin
            state_d = ST_RUN;
            advance = 1'b1;
          end
        end
        ST_DRAIN: begin
          advance      = 1'b1;
          finishOnZero = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (advance && stepToZero) begin
        wrap_d = 1'b1;
        if ((modeLatched_q == MODE_ONESHOT) && (cyclesLeft_q != '0)) begin
          cyclesLeft_d = cyclesLeft_q - CNT_W'(1);
        end
        if (finishOnZero ||
            ((modeLatched_q == MODE_ONESHOT) && (cyclesLeft_q == CNT_W'(1)))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  assign coreEn = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      modeLatched_q <= MODE_ONESHOT;
      dirLatched_q  <= DIR_UP;
      cyclesLeft_q  <= '0;
      wrap_q        <= 1'b0;
      done_q        <= 1'b0;
      errIllegal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      modeLatched_q <= modeLatched_d;
      dirLatched_q  <= dirLatched_d;
      cyclesLeft_q  <= cyclesLeft_d;
      wrap_q        <= wrap_d;
      done_q        <= done_d;
      errIllegal_q  <= errIllegal_d;
    end
  end

  // Phase is popcount on the rising half of the ring, mirrored on the falling half.
  always_comb begin
    onesCount = 0;
    for (int i = 0; i < WIDTH; i++) begin
      onesCount = onesCount + int'(count[i]);
    end
    if (count[WIDTH-1]) begin
      phaseIdx_o = PHASE_W'(2 * WIDTH - onesCount);
    end else begin
      phaseIdx_o = PHASE_W'(onesCount);
    end
  end

  assign count_o      = count;
  assign countBar_o   = ~count;
  assign busy_o       = (state_q != ST_IDLE);
  assign wrap_o       = wrap_q;
  assign done_o       = done_q;
  assign errIllegal_o = errIllegal_q;
  assign cyclesLeft_o = cyclesLeft_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed self-checking bench for johnson_seq_ctrl at WIDTH=4, CNT_W=8.
module tb_johnson_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             mode_i = 1'b0;
  logic             dir_i = 1'b0;
  logic [CNT_W-1:0] numCycles_i = '0;
  logic             pause_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [WIDTH-1:0] count_o;
  logic [WIDTH-1:0] countBar_o;
  logic [2:0]       phaseIdx_o;
  logic             busy_o;
  logic             wrap_o;
  logic             done_o;
  logic             errIllegal_o;
  logic [CNT_W-1:0] cyclesLeft_o;

  int testsRun = 0;
  int testsFailed = 0;

  logic [3:0] upSeq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always #5 clk = ~clk;

  johnson_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .dir_i        (dir_i),
    .numCycles_i  (numCycles_i),
    .pause_i      (pause_i),
    .stop_i       (stop_i),
    .count_o      (count_o),
    .countBar_o   (countBar_o),
    .phaseIdx_o   (phaseIdx_o),
    .busy_o       (busy_o),
    .wrap_o       (wrap_o),
    .done_o       (done_o),
    .errIllegal_o (errIllegal_o),
    .cyclesLeft_o (cyclesLeft_o)
  );

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start command for exactly one edge (E0).
  task automatic launch(input logic m, input logic d, input logic [CNT_W-1:0] n);
    start_i     = 1'b1;
    mode_i      = m;
    dir_i       = d;
    numCycles_i = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    testsRun++;
    if (count_o !== 4'b0000 || countBar_o !== 4'b1111 || phaseIdx_o !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_count got count=%b bar=%b phase=%0d expected 0000/1111/0",
               count_o, countBar_o, phaseIdx_o);
    end
    testsRun++;
    if ({busy_o, wrap_o, done_o, errIllegal_o} !== 4'b0000 || cyclesLeft_o !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags got busy/wrap/done/err=%b cycles=%0d expected 0000/0",
               {busy_o, wrap_o, done_o, errIllegal_o}, cyclesLeft_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_oneshot_up();
    logic [CNT_W-1:0] expCycles;
    launch(1'b0, 1'b0, 8'd2);
    testsRun++;
    if (busy_o !== 1'b1 || count_o !== 4'b0000 || cyclesLeft_o !== 8'd2) begin
      testsFailed++;
      $display("[TB] FAIL oneshot_accept got busy=%b count=%b cycles=%0d expected 1/0000/2",
               busy_o, count_o, cyclesLeft_o);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      expCycles = (k < 8) ? 8'd2 : ((k < 16) ? 8'd1 : 8'd0);
      testsRun++;
      if (count_o !== upSeq[k % 8] || phaseIdx_o !== 3'(k % 8) ||
          wrap_o !== (k % 8 == 0) || done_o !== (k == 16) ||
          busy_o !== (k != 16) || cyclesLeft_o !== expCycles) begin
        testsFailed++;
        $display("[TB] FAIL oneshot_up step %0d got count=%b phase=%0d wrap=%b done=%b busy=%b cycles=%0d expected %b/%0d/%b/%b/%b/%0d",
                 k, count_o, phaseIdx_o, wrap_o, done_o, busy_o, cyclesLeft_o,
                 upSeq[k % 8], k % 8, (k % 8 == 0), (k == 16), (k != 16), expCycles);
      end
    end
  endtask

  task automatic test_oneshot_down();
    int idx;
    launch(1'b0, 1'b1, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      idx = (8 - k) % 8;
      testsRun++;
      if (count_o !== upSeq[idx] || phaseIdx_o !== 3'(idx) ||
          done_o !== (k == 8) || wrap_o !== (k == 8) || busy_o !== (k != 8)) begin
        testsFailed++;
        $display("[TB] FAIL oneshot_down step %0d got count=%b phase=%0d done=%b wrap=%b busy=%b expected %b/%0d/%b/%b/%b",
                 k, count_o, phaseIdx_o, done_o, wrap_o, busy_o,
                 upSeq[idx], idx, (k == 8), (k == 8), (k != 8));
      end
    end
  endtask

  task automatic test_pause();
    launch(1'b1, 1'b0, 8'd0);
    tick();
    tick();
    tick();
    pause_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      testsRun++;
      if (count_o !== 4'b0111 || busy_o !== 1'b1 || cyclesLeft_o !== 8'd0) begin
        testsFailed++;
        $display("[TB] FAIL pause_hold cycle %0d got count=%b busy=%b cycles=%0d expected 0111/1/0",
                 k, count_o, busy_o, cyclesLeft_o);
      end
    end
    pause_i = 1'b0;
    tick();
    testsRun++;
    if (count_o !== 4'b1111) begin
      testsFailed++;
      $display("[TB] FAIL pause_resume got count=%b expected 1111", count_o);
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) tick();
    testsRun++;
    if (done_o !== 1'b1 || count_o !== 4'b0000 || busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pause_cleanup got done=%b count=%b busy=%b expected 1/0000/0",
               done_o, count_o, busy_o);
    end
  endtask

  task automatic test_stop_drain();
    launch(1'b1, 1'b0, 8'd0);
    tick();
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    testsRun++;
    if (count_o !== 4'b0111 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stop_first got count=%b busy=%b done=%b expected 0111/1/0",
               count_o, busy_o, done_o);
    end
    for (int j = 4; j <= 8; j++) begin
      tick();
      testsRun++;
      if (count_o !== upSeq[j % 8] || done_o !== (j == 8) || busy_o !== (j != 8)) begin
        testsFailed++;
        $display("[TB] FAIL stop_drain step %0d got count=%b done=%b busy=%b expected %b/%b/%b",
                 j, count_o, done_o, busy_o, upSeq[j % 8], (j == 8), (j != 8));
      end
    end
  endtask

  task automatic test_ignored_start();
    start_i     = 1'b1;
    mode_i      = 1'b0;
    numCycles_i = 8'd0;
    tick();
    tick();
    start_i = 1'b0;
    testsRun++;
    if (busy_o !== 1'b0 || count_o !== 4'b0000 || cyclesLeft_o !== 8'd0 || done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_start got busy=%b count=%b cycles=%0d done=%b expected 0/0000/0/0",
               busy_o, count_o, cyclesLeft_o, done_o);
    end
  endtask

  task automatic test_back_to_back();
    launch(1'b0, 1'b0, 8'd1);
    tick();
    start_i     = 1'b1;
    mode_i      = 1'b1;
    dir_i       = 1'b1;
    numCycles_i = 8'd5;
    for (int k = 2; k <= 8; k++) begin
      if (k == 5) start_i = 1'b0;
      tick();
      testsRun++;
      if (count_o !== upSeq[k % 8] || cyclesLeft_o !== ((k == 8) ? 8'd0 : 8'd1) ||
          done_o !== (k == 8) || busy_o !== (k != 8)) begin
        testsFailed++;
        $display("[TB] FAIL busy_start step %0d got count=%b cycles=%0d done=%b busy=%b expected %b/%0d/%b/%b",
                 k, count_o, cyclesLeft_o, done_o, busy_o,
                 upSeq[k % 8], (k == 8) ? 0 : 1, (k == 8), (k != 8));
      end
    end
    dir_i = 1'b0;
  endtask

  task automatic test_stop_pause_together();
    launch(1'b1, 1'b0, 8'd0);
    tick();
    pause_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    stop_i = 1'b0;
    testsRun++;
    if (count_o !== 4'b0011 || busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stop_pause_first got count=%b busy=%b expected 0011/1", count_o, busy_o);
    end
    for (int k = 3; k <= 8; k++) begin
      tick();
      testsRun++;
      if (count_o !== upSeq[k % 8] || done_o !== (k == 8)) begin
        testsFailed++;
        $display("[TB] FAIL stop_pause_drain step %0d got count=%b done=%b expected %b/%b",
                 k, count_o, done_o, upSeq[k % 8], (k == 8));
      end
    end
    pause_i = 1'b0;
  endtask

  task automatic test_illegal();
    launch(1'b1, 1'b0, 8'd0);
    tick();
    tick();
    force dut.uCore.count_q = 4'b0101;
    #1;
    release dut.uCore.count_q;
    tick();
    testsRun++;
    if (count_o !== 4'b0000 || errIllegal_o !== 1'b1 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || cyclesLeft_o !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL illegal_recover got count=%b err=%b busy=%b done=%b cycles=%0d expected 0000/1/0/0/0",
               count_o, errIllegal_o, busy_o, done_o, cyclesLeft_o);
    end
    tick();
    testsRun++;
    if (errIllegal_o !== 1'b0 || count_o !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL illegal_pulse got err=%b count=%b expected 0/0000", errIllegal_o, count_o);
    end
  endtask

  task automatic test_reset_midrun();
    launch(1'b0, 1'b0, 8'd3);
    tick();
    tick();
    tick();
    testsRun++;
    if (count_o !== 4'b0111) begin
      testsFailed++;
      $display("[TB] FAIL midrun_setup got count=%b expected 0111", count_o);
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if (count_o !== 4'b0000 || countBar_o !== 4'b1111 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || wrap_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset got count=%b bar=%b busy=%b done=%b wrap=%b expected 0000/1111/0/0/0",
               count_o, countBar_o, busy_o, done_o, wrap_o);
    end
    tick();
    rst = 1'b0;
    tick();
    testsRun++;
    if (busy_o !== 1'b0 || count_o !== 4'b0000 || done_o !== 1'b0 || wrap_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_after got busy=%b count=%b done=%b wrap=%b expected 0/0000/0/0",
               busy_o, count_o, done_o, wrap_o);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot_up();
    test_oneshot_down();
    test_pause();
    test_stop_drain();
    test_ignored_start();
    test_back_to_back();
    test_stop_pause_together();
    test_illegal();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
